prbs_checker: RTL and testbench

Serial LFSR/PRBS sequence checker: the receive end of the team's seeded LFSR pattern generator. It self-synchronises to an incoming one-bit-per-enable pattern stream and declares lock after a run of correct predictions. Once locked, it free-runs its own LFSR and flags every mismatching bit, maintaining a saturating error count. It sits on the link-test path, downstream of the generator and any channel under test.

---
 rtl/prbs_pkg.sv | 20 ++
 rtl/lfsr_step.sv | 19 +
 rtl/prbs_checker.sv | 119 +++++++++++
 tb/tb_prbs_checker.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker pair: FSM states,
// the default tap mask and the tap-parity helper both ends agree on.
package prbs_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] PRBS8_TAPS = 8'hB8;

    // Widest register the shared parity helper can serve.
    localparam int MAX_WIDTH = 64;

    function automatic logic tap_parity(input logic [MAX_WIDTH-1:0] sr,
                                        input logic [MAX_WIDTH-1:0] taps);
        return ^(sr & taps);
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR step: predicted output bit and the free-running
// next register value. Used by both generator and checker.
module lfsr_step
    import prbs_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = PRBS8_TAPS
) (
    input  logic [WIDTH-1:0] sr,
    output logic             pred,
    output logic [WIDTH-1:0] next_sr
);

    always_comb begin
        pred    = tap_parity(MAX_WIDTH'(sr), MAX_WIDTH'(TAPS));
        next_sr = {sr[WIDTH-2:0], pred};
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: fills its register from the line until a
// run of correct predictions, then free-runs and counts mismatching bits.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS        = PRBS8_TAPS,
    parameter int               LOCK_CNT    = 16,
    parameter int               LOSS_THRESH = 4,
    parameter int               ERRW        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] seed,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [ERRW-1:0]  err_count
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_THRESH + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_THRESH - 1);

    state_t            state, state_next;
    logic [WIDTH-1:0]  sr, sr_next, free_sr;
    logic [MW-1:0]     match_cnt, match_next;
    logic [LW-1:0]     miss_cnt, miss_next;
    logic              err_next;
    logic [ERRW-1:0]   cnt_next;
    logic              pred;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .sr      (sr),
        .pred    (pred),
        .next_sr (free_sr)
    );

    always_comb begin
        state_next = state;
        sr_next    = sr;
        match_next = match_cnt;
        miss_next  = miss_cnt;
        err_next   = 1'b0;
        cnt_next   = err_count;

        if (en) begin
            case (state)
                SEARCH: begin
                    sr_next = {sr[WIDTH-2:0], bit_in};
                    // An all-zero register predicts zeros forever, so it must never count.
                    if ((bit_in == pred) && (sr != '0)) begin
                        if (match_cnt == MATCH_LAST) begin
                            state_next = LOCKED;
                            match_next = '0;
                            miss_next  = '0;
                        end else begin
                            match_next = match_cnt + 1'b1;
                        end
                    end else begin
                        match_next = '0;
                    end
                end
                LOCKED: begin
                    sr_next = free_sr;
                    if (bit_in != pred) begin
                        err_next = 1'b1;
                        if (err_count != '1) begin
                            cnt_next = err_count + 1'b1;
                        end
                        if (miss_cnt == MISS_LAST) begin
                            state_next = SEARCH;
                            match_next = '0;
                            miss_next  = '0;
                        end else begin
                            miss_next = miss_cnt + 1'b1;
                        end
                    end else begin
                        miss_next = '0;
                    end
                end
                default: begin
                    state_next = SEARCH;
                end
            endcase
        end

        if (clr_cnt) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEARCH;
            sr        <= seed;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_next;
            sr        <= sr_next;
            match_cnt <= match_next;
            miss_cnt  <= miss_next;
            err       <= err_next;
            err_count <= cnt_next;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_prbs_checker.sv
// Directed-plus-random bench for prbs_checker against a history-queue
// reference model of the checker and a software pattern generator.
module tb_prbs_checker;

    localparam int         WIDTH       = 8;
    localparam logic [7:0] TAPS        = 8'hB8;
    localparam int         LOCK_CNT    = 16;
    localparam int         LOSS_THRESH = 4;
    localparam int         ERRW        = 4;
    localparam int         ERR_MAX     = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             bit_in;
    logic [WIDTH-1:0] seed;
    logic             clr_cnt;
    logic             locked;
    logic             err;
    logic [ERRW-1:0]  err_count;

    always #5 clk = ~clk;

    prbs_checker #(
        .WIDTH       (WIDTH),
        .TAPS        (TAPS),
        .LOCK_CNT    (LOCK_CNT),
        .LOSS_THRESH (LOSS_THRESH),
        .ERRW        (ERRW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .bit_in    (bit_in),
        .seed      (seed),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err       (err),
        .err_count (err_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: hist holds the register as a bit history, newest last.
    bit hist[$];
    bit m_locked;
    bit m_err;
    int m_match;
    int m_miss;
    int m_errcnt;

    logic [7:0] gen_sr;
    int         stream_idx;
    int         err_pulses;
    bit         ever_locked;
    bit         inv;
    bit         e;

    function automatic bit model_pred();
        bit p = 1'b0;
        for (int i = 0; i < WIDTH; i++)
            if (TAPS[i]) p ^= hist[hist.size() - 1 - i];
        return p;
    endfunction

    function automatic bit model_nonzero();
        bit nz = 1'b0;
        for (int i = 0; i < hist.size(); i++) nz |= hist[i];
        return nz;
    endfunction

    task automatic model_reset(input logic [7:0] s);
        hist.delete();
        for (int i = WIDTH - 1; i >= 0; i--) hist.push_back(s[i]);
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_match  = 0;
        m_miss   = 0;
        m_errcnt = 0;
    endtask

    task automatic model_step(input bit me, input bit mb, input bit mc);
        bit p;
        m_err = 1'b0;
        if (me) begin
            p = model_pred();
            if (!m_locked) begin
                if (mb == p && model_nonzero()) begin
                    m_match++;
                    if (m_match == LOCK_CNT) begin
                        m_locked = 1'b1;
                        m_match  = 0;
                        m_miss   = 0;
                    end
                end else begin
                    m_match = 0;
                end
                hist.push_back(mb);
            end else begin
                if (mb != p) begin
                    m_err = 1'b1;
                    if (m_errcnt < ERR_MAX) m_errcnt++;
                    m_miss++;
                    if (m_miss == LOSS_THRESH) begin
                        m_locked = 1'b0;
                        m_match  = 0;
                        m_miss   = 0;
                    end
                end else begin
                    m_miss = 0;
                end
                hist.push_back(p);
            end
            void'(hist.pop_front());
        end
        if (mc) m_errcnt = 0;
    endtask

    task automatic applyStimulus(input logic r, input logic ae, input logic ab,
                                 input logic ac, input logic [7:0] s);
        reset   = r;
        en      = ae;
        bit_in  = ab;
        clr_cnt = ac;
        seed    = s;
        @(posedge clk);
        if (r) model_reset(s);
        else   model_step(ae, ab, ac);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".locked"},    locked,    m_locked);
        checkValue({tag, ".err"},       err,       m_err);
        checkValue({tag, ".err_count"}, err_count, m_errcnt);
    endtask

    // Sends the next generator bit (optionally inverted); the generator only advances on en.
    task automatic sendBit(input bit flip, input bit se, input bit sc, input string tag);
        bit g;
        g = ^(gen_sr & TAPS);
        applyStimulus(1'b0, se, se ? (g ^ flip) : 1'($urandom), sc, seed);
        if (se) begin
            gen_sr = {gen_sr[6:0], g};
            stream_idx++;
        end
        checkOutput(tag);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; bit_in = 1'b0; clr_cnt = 1'b0; seed = '0;

        $display("[TB] reset and clean lock");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("reset");
        checkValue("reset.sr", dut.sr, 8'h00);

        gen_sr     = 8'h01;
        stream_idx = 0;
        repeat (40) sendBit(1'b0, 1'b1, 1'b0, "clean");
        checkValue("clean.locked_final", locked, 1'b1);
        checkValue("clean.err_count", err_count, 0);

        $display("[TB] single bit errors");
        err_pulses = 0;
        while (stream_idx < 120) begin
            if (stream_idx == 50 || stream_idx == 90) begin
                sendBit(1'b1, 1'b1, 1'b0, "single");
                checkValue("single.err_pulse", err, 1'b1);
            end else begin
                sendBit(1'b0, 1'b1, 1'b0, "single");
            end
            if (err) err_pulses++;
        end
        checkValue("single.pulses", err_pulses, 2);
        checkValue("single.err_count", err_count, 2);
        checkValue("single.locked", locked, 1'b1);

        $display("[TB] loss of lock and relock");
        sendBit(1'b0, 1'b0, 1'b1, "clr");
        checkValue("clr.err_count", err_count, 0);
        for (int i = 0; i < 4; i++) begin
            sendBit(1'b1, 1'b1, 1'b0, "loss");
            checkValue("loss.err_pulse", err, 1'b1);
            checkValue("loss.locked_hold", locked, (i < 3) ? 1'b1 : 1'b0);
        end
        checkValue("loss.err_count", err_count, 4);
        repeat (15) sendBit(1'b0, 1'b1, 1'b0, "relock");
        checkValue("relock.not_yet", locked, 1'b0);
        sendBit(1'b0, 1'b1, 1'b0, "relock");
        checkValue("relock.locked", locked, 1'b1);

        $display("[TB] idle line");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom_range(1, 255)));
        checkOutput("idle_reset");
        checkValue("idle_reset.sr", dut.sr, seed);
        ever_locked = 1'b0;
        repeat (200) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, seed);
            checkOutput("idle");
            ever_locked |= locked;
        end
        checkValue("idle.never_locked", ever_locked, 1'b0);
        checkValue("idle.err_count", err_count, 0);

        $display("[TB] enable gaps and saturation");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
        checkOutput("sat_reset");
        gen_sr = 8'h01;
        repeat (15) sendBit(1'b0, 1'b1, 1'b0, "sat_lock");
        checkValue("sat_lock.not_yet", locked, 1'b0);
        sendBit(1'b0, 1'b1, 1'b0, "sat_lock");
        checkValue("sat_lock.locked", locked, 1'b1);
        inv = 1'b0;
        repeat (150) begin
            e = 1'($urandom);
            sendBit(e && inv, e, 1'b0, "sat");
            if (!e) checkValue("sat.no_err_gap", err, 1'b0);
            if (e) inv = !inv;
        end
        checkValue("sat.err_count", err_count, 4'hF);
        checkValue("sat.locked", locked, 1'b1);
        sendBit(1'b0, 1'b1, 1'b0, "sat_pre");
        sendBit(1'b1, 1'b1, 1'b1, "clr_vs_inc");
        checkValue("clr_vs_inc.err", err, 1'b1);
        checkValue("clr_vs_inc.err_count", err_count, 0);

        $display("[TB] reset mid-lock");
        sendBit(1'b0, 1'b1, 1'b0, "midlock");
        for (int i = 0; i < 3; i++) begin
            sendBit(1'b1, 1'b1, 1'b0, "midlock");
            sendBit(1'b0, 1'b1, 1'b0, "midlock");
        end
        checkValue("midlock.err_count", err_count, 3);
        checkValue("midlock.locked", locked, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h5A);
        checkOutput("midreset");
        checkValue("midreset.locked", locked, 1'b0);
        checkValue("midreset.err_count", err_count, 0);
        checkValue("midreset.sr", dut.sr, 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
